mem_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between the instruction-fetch port (IF) and the data-memory port (DM) of the 16-bit CPU.
- Sequences each access: grant, one-cycle command pulse, wait for memory valid, return data with a done pulse.
- Sits between the fetch stage / MEM stage (driven by MemRead/MemWrite decode) and the memory model.
- Includes a watchdog that aborts accesses the memory never completes.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arb_wdog.sv | 37 +++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and defaults for the unified-memory arbiter slice.
//   state_t : arbiter FSM encoding (IDLE / BUSY_IF / BUSY_DM)
//   port_t  : requester identity (PORT_IF / PORT_DM)
//   DEFAULT_* : default widths and watchdog limit
//   wdog_width() : counter width needed to hold a given timeout value
package mem_arb_pkg;

   localparam int DEFAULT_ADDR_W  = 16;
   localparam int DEFAULT_DATA_W  = 16;
   localparam int DEFAULT_TIMEOUT = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } state_t;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_DM = 1'b1
   } port_t;

   // A zero or one timeout still needs a one-bit counter so the
   // watchdog compare stays well formed.
   function automatic int wdog_width(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the fetch port, data port and memory command/response signals.
//   slave  : the arbiter side (takes requests and memory responses)
//   master : the environment side (CPU ports plus memory model)
// Signals:
//   if_req/if_addr -> if_rdata/if_done          fetch read port
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_done   data port
//   mem_en/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_valid   memory
//   busy, err                                   status
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W
) ();

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_done;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;

   logic              busy;
   logic              err;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
             mem_rdata, mem_valid,
      output if_rdata, if_done, dm_rdata, dm_done,
             mem_en, mem_we, mem_addr, mem_wdata, busy, err
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
             mem_rdata, mem_valid,
      input  if_rdata, if_done, dm_rdata, dm_done,
             mem_en, mem_we, mem_addr, mem_wdata, busy, err
   );

endinterface

// File: rtl/mem_arb_wdog.sv
// mem_arb_wdog
// Access watchdog: counts cycles an issued access has been waiting.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero the count (access being issued)
//   run        : advance the count (busy cycle without completion)
//   expired    : count has reached TIMEOUT (never asserted when TIMEOUT=0)
module mem_arb_wdog
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic expired
);

   localparam int CNT_W = wdog_width(TIMEOUT);

   logic [CNT_W-1:0] count;

   assign expired = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT));

   // Saturates at the limit so a stalled FSM can never wrap the count
   // back below TIMEOUT and miss the abort.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (run && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one variable-latency memory between instruction fetch (IF) and
// data memory (DM). Each access: grant in IDLE, one-cycle mem_en pulse,
// wait for mem_valid, then a one-cycle done pulse with read data.
// A watchdog aborts accesses that never complete (rdata=0, sticky err).
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mem_arbiter_if.slave (requests, responses, memory, busy/err)
// Build option:
//   MEM_ARB_FAIR_EN defined   -> round-robin on simultaneous requests
//   MEM_ARB_FAIR_EN undefined -> DM always wins a tie
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input logic           clk,
   input logic           rst_n,
   mem_arbiter_if.slave  bus
);

   state_t            state;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic              if_done_q;
   logic              dm_done_q;
   logic              err_q;

   logic              if_elig;
   logic              dm_elig;
   logic              grant_if;
   logic              grant_dm;
   logic              valid_eff;
   logic              wd_run;
   logic              expired;

`ifdef MEM_ARB_FAIR_EN
   port_t             last_grant;
`endif

   // A response in the command cycle belongs to nothing we issued, so
   // only mem_valid after the mem_en pulse counts.
   assign valid_eff = bus.mem_valid && !mem_en_q;
   assign wd_run    = (state != IDLE) && !valid_eff;

   // Grant decision. A port whose done is high this cycle is masked so
   // a requester still lowering req is not granted a phantom access.
   always_comb begin
      if_elig  = bus.if_req && !if_done_q;
      dm_elig  = bus.dm_req && !dm_done_q;
      grant_if = 1'b0;
      grant_dm = 1'b0;
      if (state == IDLE) begin
         if (if_elig && dm_elig) begin
`ifdef MEM_ARB_FAIR_EN
            if (last_grant == PORT_DM) begin
               grant_if = 1'b1;
            end else begin
               grant_dm = 1'b1;
            end
`else
            grant_dm = 1'b1;
`endif
         end else begin
            grant_if = if_elig;
            grant_dm = dm_elig;
         end
      end
   end

   mem_arb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (grant_if || grant_dm),
      .run     (wd_run),
      .expired (expired)
   );

   // Main FSM with registered outputs. Command fields are captured at
   // issue and left untouched until the next issue, so they stay stable
   // for the whole access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_done_q   <= 1'b0;
         dm_done_q   <= 1'b0;
         err_q       <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
         last_grant  <= PORT_IF;
`endif
      end else begin
         mem_en_q  <= 1'b0;
         if_done_q <= 1'b0;
         dm_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_dm) begin
                  state       <= BUSY_DM;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= bus.dm_we;
                  mem_addr_q  <= bus.dm_addr;
                  mem_wdata_q <= bus.dm_wdata;
`ifdef MEM_ARB_FAIR_EN
                  last_grant  <= PORT_DM;
`endif
               end else if (grant_if) begin
                  state       <= BUSY_IF;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= bus.if_addr;
                  mem_wdata_q <= '0;
`ifdef MEM_ARB_FAIR_EN
                  last_grant  <= PORT_IF;
`endif
               end
            end
            BUSY_IF: begin
               if (valid_eff) begin
                  if_done_q  <= 1'b1;
                  if_rdata_q <= bus.mem_rdata;
                  state      <= IDLE;
               end else if (expired) begin
                  if_done_q  <= 1'b1;
                  if_rdata_q <= '0;
                  err_q      <= 1'b1;
                  state      <= IDLE;
               end
            end
            BUSY_DM: begin
               if (valid_eff) begin
                  dm_done_q  <= 1'b1;
                  dm_rdata_q <= bus.mem_rdata;
                  state      <= IDLE;
               end else if (expired) begin
                  dm_done_q  <= 1'b1;
                  dm_rdata_q <= '0;
                  err_q      <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.dm_done   = dm_done_q;
   assign bus.err       = err_q;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with TIMEOUT=8. Inputs change 1 ns after
// each rising edge and outputs are checked at that same point, so each
// "cycle" below is the interval following a clock edge.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 8;
`ifdef MEM_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   bit   first_is_dm;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ifr, input logic [15:0] ifa,
                                input logic dmr, input logic dmw,
                                input logic [15:0] dma, input logic [15:0] dmd);
      bus.if_req   = ifr;
      bus.if_addr  = ifa;
      bus.dm_req   = dmr;
      bus.dm_we    = dmw;
      bus.dm_addr  = dma;
      bus.dm_wdata = dmd;
   endtask

   task automatic driveMem(input logic v, input logic [15:0] d);
      bus.mem_valid = v;
      bus.mem_rdata = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_busy"},     bus.busy,      0);
      checkOutput({tag, "_err"},      bus.err,       0);
      checkOutput({tag, "_mem_en"},   bus.mem_en,    0);
      checkOutput({tag, "_mem_we"},   bus.mem_we,    0);
      checkOutput({tag, "_mem_addr"}, bus.mem_addr,  0);
      checkOutput({tag, "_mem_wd"},   bus.mem_wdata, 0);
      checkOutput({tag, "_if_done"},  bus.if_done,   0);
      checkOutput({tag, "_if_rd"},    bus.if_rdata,  0);
      checkOutput({tag, "_dm_done"},  bus.dm_done,   0);
      checkOutput({tag, "_dm_rd"},    bus.dm_rdata,  0);
   endtask

   initial begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      driveMem(0, 0);
      rst_n = 1'b0;
      repeat (2) tick();
      checkResetState("rst");
      rst_n = 1'b1;
      tick();

      // DM read, latency 3
      $display("[TB] dm read L=3");
      applyStimulus(0, 0, 1, 0, 16'h0040, 0);
      checkOutput("t1_en_c0", bus.mem_en, 0);
      tick();
      checkOutput("t1_en_c1", bus.mem_en, 1);
      checkOutput("t1_addr", bus.mem_addr, 16'h0040);
      checkOutput("t1_we", bus.mem_we, 0);
      checkOutput("t1_busy", bus.busy, 1);
      repeat (3) tick();
      driveMem(1, 16'hBEEF);
      tick();
      checkOutput("t1_dm_done", bus.dm_done, 1);
      checkOutput("t1_dm_rdata", bus.dm_rdata, 16'hBEEF);
      checkOutput("t1_if_done", bus.if_done, 0);
      checkOutput("t1_busy_end", bus.busy, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      driveMem(0, 0);
      tick();
      checkOutput("t1_done_low", bus.dm_done, 0);
      checkOutput("t1_no_reissue", bus.mem_en, 0);

      // Simultaneous requests, latency 1 (last grant was DM)
      $display("[TB] simultaneous IF+DM L=1");
      first_is_dm = !FAIR;
      applyStimulus(1, 16'h0100, 1, 0, 16'h0200, 0);
      tick();
      checkOutput("t2_en1", bus.mem_en, 1);
      checkOutput("t2_addr1", bus.mem_addr, first_is_dm ? 16'h0200 : 16'h0100);
      tick();
      driveMem(1, 16'h1111);
      tick();
      checkOutput("t2_dm_done1", bus.dm_done, first_is_dm);
      checkOutput("t2_if_done1", bus.if_done, !first_is_dm);
      checkOutput("t2_en_gap", bus.mem_en, 0);
      driveMem(0, 0);
      if (first_is_dm) applyStimulus(1, 16'h0100, 0, 0, 0, 0);
      else             applyStimulus(0, 0, 1, 0, 16'h0200, 0);
      tick();
      checkOutput("t2_en2", bus.mem_en, 1);
      checkOutput("t2_addr2", bus.mem_addr, first_is_dm ? 16'h0100 : 16'h0200);
      tick();
      driveMem(1, 16'h2222);
      tick();
      checkOutput("t2_if_done2", bus.if_done, first_is_dm);
      checkOutput("t2_dm_done2", bus.dm_done, !first_is_dm);
      checkOutput("t2_if_rdata", bus.if_rdata, first_is_dm ? 16'h2222 : 16'h1111);
      checkOutput("t2_dm_rdata", bus.dm_rdata, first_is_dm ? 16'h1111 : 16'h2222);
      applyStimulus(0, 0, 0, 0, 0, 0);
      driveMem(0, 0);
      tick();

      // DM write, latency 2
      $display("[TB] dm write");
      applyStimulus(0, 0, 1, 1, 16'h0010, 16'h1234);
      tick();
      checkOutput("t3_en", bus.mem_en, 1);
      checkOutput("t3_we", bus.mem_we, 1);
      checkOutput("t3_addr", bus.mem_addr, 16'h0010);
      checkOutput("t3_wdata", bus.mem_wdata, 16'h1234);
      tick();
      checkOutput("t3_en_low", bus.mem_en, 0);
      checkOutput("t3_wdata_hold", bus.mem_wdata, 16'h1234);
      tick();
      checkOutput("t3_we_hold", bus.mem_we, 1);
      driveMem(1, 16'hFFFF);
      tick();
      checkOutput("t3_dm_done", bus.dm_done, 1);
      checkOutput("t3_if_done", bus.if_done, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      driveMem(0, 0);
      tick();
      checkOutput("t3_single_pulse", bus.dm_done, 0);
      checkOutput("t3_if_done_end", bus.if_done, 0);

      // Requester keeps req high through its done cycle
      $display("[TB] req held through done");
      applyStimulus(0, 0, 1, 0, 16'h0020, 0);
      tick();
      checkOutput("t4_en1", bus.mem_en, 1);
      tick();
      driveMem(1, 16'hAAAA);
      tick();
      checkOutput("t4_done1", bus.dm_done, 1);
      checkOutput("t4_rdata1", bus.dm_rdata, 16'hAAAA);
      driveMem(0, 0);
      tick();
      checkOutput("t4_no_en_after_done", bus.mem_en, 0);
      checkOutput("t4_idle", bus.busy, 0);
      tick();
      checkOutput("t4_en2", bus.mem_en, 1);
      tick();
      driveMem(1, 16'hBBBB);
      tick();
      checkOutput("t4_done2", bus.dm_done, 1);
      checkOutput("t4_rdata2", bus.dm_rdata, 16'hBBBB);
      applyStimulus(0, 0, 0, 0, 0, 0);
      driveMem(0, 0);
      tick();

      // mem_valid coincident with mem_en must be ignored
      $display("[TB] valid during command cycle");
      applyStimulus(0, 0, 1, 0, 16'h0030, 0);
      tick();
      checkOutput("t7_en", bus.mem_en, 1);
      driveMem(1, 16'h9999);
      tick();
      checkOutput("t7_no_done", bus.dm_done, 0);
      checkOutput("t7_busy", bus.busy, 1);
      driveMem(1, 16'h7777);
      tick();
      checkOutput("t7_done", bus.dm_done, 1);
      checkOutput("t7_rdata", bus.dm_rdata, 16'h7777);
      applyStimulus(0, 0, 0, 0, 0, 0);
      driveMem(0, 0);
      tick();

      // Watchdog: memory never answers an IF read
      $display("[TB] watchdog timeout");
      applyStimulus(1, 16'h0300, 0, 0, 0, 0);
      tick();
      checkOutput("t5_en", bus.mem_en, 1);
      checkOutput("t5_addr", bus.mem_addr, 16'h0300);
      repeat (8) tick();
      checkOutput("t5_not_yet", bus.if_done, 0);
      checkOutput("t5_busy_wait", bus.busy, 1);
      checkOutput("t5_err_low", bus.err, 0);
      tick();
      checkOutput("t5_done", bus.if_done, 1);
      checkOutput("t5_rdata0", bus.if_rdata, 0);
      checkOutput("t5_err", bus.err, 1);
      checkOutput("t5_idle", bus.busy, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("t5_err_sticky", bus.err, 1);
      checkOutput("t5_done_low", bus.if_done, 0);
      applyStimulus(0, 0, 1, 0, 16'h0050, 0);
      tick();
      checkOutput("t5_next_en", bus.mem_en, 1);
      checkOutput("t5_next_addr", bus.mem_addr, 16'h0050);
      tick();
      driveMem(1, 16'h5A5A);
      tick();
      checkOutput("t5_next_done", bus.dm_done, 1);
      checkOutput("t5_next_rdata", bus.dm_rdata, 16'h5A5A);
      checkOutput("t5_err_still", bus.err, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      driveMem(0, 0);
      tick();

      // Reset during BUSY_DM, late mem_valid afterwards
      $display("[TB] reset mid-access");
      applyStimulus(0, 0, 1, 0, 16'h0060, 0);
      tick();
      checkOutput("t6_en", bus.mem_en, 1);
      tick();
      rst_n = 1'b0;
      tick();
      checkResetState("t6_rst");
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      driveMem(1, 16'hDEAD);
      tick();
      checkOutput("t6_no_done", bus.dm_done, 0);
      checkOutput("t6_rdata0", bus.dm_rdata, 0);
      checkOutput("t6_idle", bus.busy, 0);
      checkOutput("t6_no_en", bus.mem_en, 0);
      driveMem(0, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
